// File: rtl/ktms_afu_rsp_intr.sv
// -----------------------------------------------------------------------------
// ktms_afu_rsp_intr
//
// Purpose:
//   Takes the completion stream from the RRQ writer and, for completions that
//   request one, raises an interrupt for their context before the completion
//   is released. Completions without an interrupt pass straight through. Only
//   one transaction is in flight at a time, and transactions stay in order.
//
// Optional feature (compile-time macro):
//   KTMS_RSP_INTR_RETRY_EN - a nonzero interrupt return code is reissued up to
//   max_retry times, with backoff_cycles idle cycles before each reissue.
//   When the macro is not defined, a nonzero rc goes straight to the error path,
//   and the backoff state and counters are not built.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   i_rsp_v / i_rsp_r            completion input handshake
//   i_rsp_ctxt                   context id; the LSB is odd parity over the upper bits
//   i_rsp_nocmpl                 1 = drop the completion after any interrupt
//   i_rsp_sintr_v, i_rsp_sintr_id  request an interrupt, and its source id
//   i_rsp_aux                    opaque tag, passed through unchanged
//   o_intr_v / o_intr_r          interrupt command handshake (ctxt, id)
//   i_intr_done_v / i_intr_done_r  interrupt done handshake, i_intr_done_rc (0 = ok)
//   o_cmpl_v / o_cmpl_r          completion output handshake (aux, err)
//   o_intr_cnt                   count of successful interrupts, saturating
//   o_perror                     sticky context parity error
// -----------------------------------------------------------------------------
module ktms_afu_rsp_intr #(
    parameter int ctxtid_width   = 9,
    parameter int sintrid_width  = 4,
    parameter int aux_width      = 8,
    parameter int dma_rc_width   = 8,
    parameter int max_retry      = 3,
    parameter int backoff_cycles = 16
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     i_rsp_v,
    output logic                     i_rsp_r,
    input  logic [ctxtid_width-1:0]  i_rsp_ctxt,
    input  logic                     i_rsp_nocmpl,
    input  logic                     i_rsp_sintr_v,
    input  logic [sintrid_width-1:0] i_rsp_sintr_id,
    input  logic [aux_width-1:0]     i_rsp_aux,

    output logic                     o_intr_v,
    input  logic                     o_intr_r,
    output logic [ctxtid_width-1:0]  o_intr_ctxt,
    output logic [sintrid_width-1:0] o_intr_id,

    input  logic                     i_intr_done_v,
    output logic                     i_intr_done_r,
    input  logic [dma_rc_width-1:0]  i_intr_done_rc,

    output logic                     o_cmpl_v,
    input  logic                     o_cmpl_r,
    output logic [aux_width-1:0]     o_cmpl_aux,
    output logic                     o_cmpl_err,
    output logic [31:0]              o_intr_cnt,
    output logic                     o_perror
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CMPL    = 3'd3
`ifdef KTMS_RSP_INTR_RETRY_EN
        ,
        ST_BACKOFF = 3'd4
`endif
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Holding register for the transaction in flight.
    logic [ctxtid_width-1:0]  r_ctxt;
    logic [sintrid_width-1:0] r_id;
    logic [aux_width-1:0]     r_aux;
    logic                     r_nocmpl;
    logic                     r_err;
    logic [31:0]              r_intr_cnt;
    logic                     r_perror;

    logic w_accept;
    logic w_done_acc;
    logic w_rc_ok;
    logic w_par_err;
    logic w_retry_ok;

    assign w_accept   = i_rsp_v & i_rsp_r;
    assign w_done_acc = i_intr_done_v & i_intr_done_r;
    assign w_rc_ok    = (i_intr_done_rc == '0);
    // Context parity is odd over the whole field, so an even count of ones is an error.
    assign w_par_err  = ~(^i_rsp_ctxt);

    // ------------------------------------------------------------------------
    // Retry bookkeeping (only built with the retry feature)
    // ------------------------------------------------------------------------
`ifdef KTMS_RSP_INTR_RETRY_EN
    localparam int                 RETRY_W      = (max_retry > 0) ? $clog2(max_retry + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(max_retry);
    localparam logic [7:0]         BACKOFF_INIT = 8'(backoff_cycles);

    logic [RETRY_W-1:0] r_retry;
    logic [7:0]         r_backoff;
    logic               w_backoff_last;

    assign w_retry_ok     = (r_retry < RETRY_MAX);
    assign w_backoff_last = (r_backoff == 8'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retry   <= '0;
            r_backoff <= '0;
        end else begin
            if (w_accept) begin
                r_retry <= '0;
            end
            // The retry count advances on entry to BACKOFF; the counter is loaded
            // so that BACKOFF lasts exactly backoff_cycles cycles.
            if (w_done_acc && !w_rc_ok && w_retry_ok) begin
                r_retry   <= r_retry + RETRY_W'(1);
                r_backoff <= BACKOFF_INIT;
            end else if (r_state == ST_BACKOFF) begin
                r_backoff <= r_backoff - 8'd1;
            end
        end
    end
`else
    // Retry parameters have no effect in this build.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{32'(max_retry), 32'(backoff_cycles)};
    assign w_retry_ok   = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: w_state_nxt gets its default before the case so that every path
    // assigns it; a path that left it unassigned would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (i_rsp_sintr_v)      w_state_nxt = ST_ISSUE;
                    else if (!i_rsp_nocmpl) w_state_nxt = ST_CMPL;
                    else                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (o_intr_r) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_intr_done_v) begin
`ifdef KTMS_RSP_INTR_RETRY_EN
                    if (!w_rc_ok && w_retry_ok) w_state_nxt = ST_BACKOFF;
                    else
`endif
                    if (r_nocmpl)               w_state_nxt = ST_IDLE;
                    else                        w_state_nxt = ST_CMPL;
                end
            end
`ifdef KTMS_RSP_INTR_RETRY_EN
            ST_BACKOFF: begin
                if (w_backoff_last) w_state_nxt = ST_ISSUE;
            end
`endif
            ST_CMPL: begin
                if (o_cmpl_r) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // State and holding registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            // NOTE: the holding register is a handful of flops rather than a
            // memory, so clearing it costs nothing and keeps outputs defined.
            r_ctxt     <= '0;
            r_id       <= '0;
            r_aux      <= '0;
            r_nocmpl   <= 1'b0;
            r_err      <= 1'b0;
            r_intr_cnt <= '0;
            r_perror   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ctxt   <= i_rsp_ctxt;
                r_id     <= i_rsp_sintr_id;
                r_aux    <= i_rsp_aux;
                r_nocmpl <= i_rsp_nocmpl;
                r_err    <= 1'b0;
                r_perror <= r_perror | w_par_err;
            end
            if (w_done_acc) begin
                if (w_rc_ok) begin
                    if (r_intr_cnt != 32'hFFFF_FFFF) r_intr_cnt <= r_intr_cnt + 32'd1;
                end else if (!w_retry_ok) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Handshake outputs are also masked by reset so that they read 0 while reset
    // is held, including the cycle before the first reset edge.
    assign i_rsp_r       = ~reset & (r_state == ST_IDLE);
    assign o_intr_v      = ~reset & (r_state == ST_ISSUE);
    assign i_intr_done_r = ~reset & (r_state == ST_WAIT);
    assign o_cmpl_v      = ~reset & (r_state == ST_CMPL);

    assign o_intr_ctxt = r_ctxt;
    assign o_intr_id   = r_id;
    assign o_cmpl_aux  = r_aux;
    assign o_cmpl_err  = r_err;
    assign o_intr_cnt  = r_intr_cnt;
    assign o_perror    = r_perror;

endmodule

// File: tb/tb_ktms_afu_rsp_intr.sv
// -----------------------------------------------------------------------------
// tb_ktms_afu_rsp_intr
//
// Scoreboarded bench for ktms_afu_rsp_intr. The stimulus side pushes expected
// interrupt commands, completions and the rc sequence to return; a negedge
// monitor pops and compares on each output handshake and checks latencies.
// Honours KTMS_RSP_INTR_RETRY_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_ktms_afu_rsp_intr;

    localparam int BACKOFF = 16;
`ifdef KTMS_RSP_INTR_RETRY_EN
    localparam int MAX_ATT = 4;   // one issue plus three retries
`else
    localparam int MAX_ATT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        i_rsp_v;
    logic        i_rsp_r;
    logic [8:0]  i_rsp_ctxt;
    logic        i_rsp_nocmpl;
    logic        i_rsp_sintr_v;
    logic [3:0]  i_rsp_sintr_id;
    logic [7:0]  i_rsp_aux;
    logic        o_intr_v;
    logic        o_intr_r;
    logic [8:0]  o_intr_ctxt;
    logic [3:0]  o_intr_id;
    logic        i_intr_done_v;
    logic        i_intr_done_r;
    logic [7:0]  i_intr_done_rc;
    logic        o_cmpl_v;
    logic        o_cmpl_r;
    logic [7:0]  o_cmpl_aux;
    logic        o_cmpl_err;
    logic [31:0] o_intr_cnt;
    logic        o_perror;

    ktms_afu_rsp_intr dut (
        .clk            (clk),
        .reset          (reset),
        .i_rsp_v        (i_rsp_v),
        .i_rsp_r        (i_rsp_r),
        .i_rsp_ctxt     (i_rsp_ctxt),
        .i_rsp_nocmpl   (i_rsp_nocmpl),
        .i_rsp_sintr_v  (i_rsp_sintr_v),
        .i_rsp_sintr_id (i_rsp_sintr_id),
        .i_rsp_aux      (i_rsp_aux),
        .o_intr_v       (o_intr_v),
        .o_intr_r       (o_intr_r),
        .o_intr_ctxt    (o_intr_ctxt),
        .o_intr_id      (o_intr_id),
        .i_intr_done_v  (i_intr_done_v),
        .i_intr_done_r  (i_intr_done_r),
        .i_intr_done_rc (i_intr_done_rc),
        .o_cmpl_v       (o_cmpl_v),
        .o_cmpl_r       (o_cmpl_r),
        .o_cmpl_aux     (o_cmpl_aux),
        .o_cmpl_err     (o_cmpl_err),
        .o_intr_cnt     (o_intr_cnt),
        .o_perror       (o_perror)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    typedef struct { logic [8:0] ctxt; logic [3:0] id; } intr_exp_t;
    typedef struct { logic [7:0] aux; logic err; logic [31:0] cnt; } cmpl_exp_t;

    intr_exp_t   exp_intr_q[$];
    cmpl_exp_t   exp_cmpl_q[$];
    logic [7:0]  rc_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_cnt  = '0;
    bit          model_perr = 1'b0;
    bit          rand_rdy   = 1'b0;
    bit          hold_done  = 1'b0;
    int          n_issue    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Build a context id with odd overall parity (or deliberately even).
    function automatic logic [8:0] mk_ctxt(input logic [7:0] upper, input bit bad);
        logic p;
        p = ($countones(upper) % 2 == 0);
        if (bad) p = ~p;
        return {upper, p};
    endfunction

    // ---------------- stimulus ----------------
    // Pushes expectations from the high-level rules, then drives the request
    // until it is accepted. nfail = how many leading done responses carry rc!=0.
    task automatic send(input logic [8:0] ctxt, input logic sintr, input logic [3:0] id,
                        input logic nocmpl, input logic [7:0] aux, input int nfail);
        int  att;
        bit  err;
        int  n;
        att = 0;
        err = 1'b0;
        if (sintr) begin
            att = (nfail + 1 < MAX_ATT) ? nfail + 1 : MAX_ATT;
            err = (nfail >= MAX_ATT);
            for (int i = 0; i < att; i++) begin
                exp_intr_q.push_back('{ctxt, id});
                rc_q.push_back((i < nfail) ? 8'($urandom_range(1, 255)) : 8'h00);
            end
            if (!err && model_cnt != 32'hFFFF_FFFF) model_cnt++;
        end
        if (!nocmpl) exp_cmpl_q.push_back('{aux, err, model_cnt});

        i_rsp_ctxt     = ctxt;
        i_rsp_sintr_v  = sintr;
        i_rsp_sintr_id = id;
        i_rsp_nocmpl   = nocmpl;
        i_rsp_aux      = aux;
        i_rsp_v        = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!i_rsp_r && n < 3000);
        if (!i_rsp_r) check("rsp_accept_timeout", {63'd0, i_rsp_r}, 64'd1);
        @(posedge clk);
        #1;
        i_rsp_v = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_intr_q.size() == 0 && exp_cmpl_q.size() == 0 && rc_q.size() == 0 &&
                     i_rsp_r && !i_intr_done_v) && n < 5000);
        check(name, 64'(n < 5000), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_r"},     {63'd0, i_rsp_r},       64'd0);
        check({tag, "_intr_v"},    {63'd0, o_intr_v},      64'd0);
        check({tag, "_done_r"},    {63'd0, i_intr_done_r}, 64'd0);
        check({tag, "_cmpl_v"},    {63'd0, o_cmpl_v},      64'd0);
        check({tag, "_intr_cnt"},  64'(o_intr_cnt),        64'd0);
        check({tag, "_perror"},    {63'd0, o_perror},      64'd0);
    endtask

    // ---------------- ready drivers ----------------
    initial begin
        o_intr_r = 1'b1;
        o_cmpl_r = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) begin
                o_intr_r = 1'($urandom_range(0, 1));
                o_cmpl_r = ($urandom_range(0, 3) != 0);
            end else begin
                o_intr_r = 1'b1;
                o_cmpl_r = 1'b1;
            end
        end
    end

    // ---------------- interrupt done responder ----------------
    initial begin
        int d;
        int n;
        i_intr_done_v  = 1'b0;
        i_intr_done_rc = '0;
        forever begin
            @(negedge clk);
            if (!reset && o_intr_v && o_intr_r && !hold_done) begin
                d = rand_rdy ? int'($urandom_range(0, 3)) : 0;
                @(posedge clk);
                repeat (d) @(posedge clk);
                #1;
                i_intr_done_v  = 1'b1;
                i_intr_done_rc = (rc_q.size() != 0) ? rc_q.pop_front() : 8'h00;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!i_intr_done_r && n < 1000);
                if (!i_intr_done_r) check("done_accept_timeout", {63'd0, i_intr_done_r}, 64'd1);
                @(posedge clk);
                #1;
                i_intr_done_v = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    int  acc_cyc  = 0;
    int  done_cyc = 0;
    int  cur_att  = 0;
    bit  cur_intr, cur_nocmpl;
    bit  perr_pend, idle_pend;
    bit  prev_intr_v, prev_cmpl_v;

    always @(negedge clk) begin
        if (reset) begin
            perr_pend = 1'b0;
            idle_pend = 1'b0;
        end else begin
            if (perr_pend) begin
                check("perror", {63'd0, o_perror}, {63'd0, model_perr});
                perr_pend = 1'b0;
            end
            if (idle_pend) begin
                check("idle_next_cycle", {63'd0, i_rsp_r}, 64'd1);
                idle_pend = 1'b0;
            end
            if (i_rsp_v && i_rsp_r) begin
                acc_cyc    = cyc;
                cur_intr   = i_rsp_sintr_v;
                cur_nocmpl = i_rsp_nocmpl;
                cur_att    = 0;
                if ($countones(i_rsp_ctxt) % 2 == 0) model_perr = 1'b1;
                perr_pend  = 1'b1;
                if (!i_rsp_sintr_v && i_rsp_nocmpl) idle_pend = 1'b1;
            end
            if (o_intr_v && !prev_intr_v)
                check("intr_latency", 64'(cyc),
                      64'((cur_att == 0) ? acc_cyc + 1 : done_cyc + BACKOFF + 1));
            if (o_intr_v && o_intr_r) begin
                check("intr_expected", 64'(exp_intr_q.size() != 0), 64'd1);
                if (exp_intr_q.size() != 0) begin
                    intr_exp_t e;
                    e = exp_intr_q.pop_front();
                    check("intr_ctxt", 64'(o_intr_ctxt), 64'(e.ctxt));
                    check("intr_id",   64'(o_intr_id),   64'(e.id));
                end
                cur_att++;
                n_issue++;
            end
            // A done offered while the design is not waiting would be premature.
            if (i_intr_done_v) check("done_ready", {63'd0, i_intr_done_r}, 64'd1);
            if (i_intr_done_v && i_intr_done_r) begin
                done_cyc = cyc;
                if ((i_intr_done_rc == 8'h00 || cur_att >= MAX_ATT) && cur_nocmpl) idle_pend = 1'b1;
            end
            if (o_cmpl_v && !prev_cmpl_v)
                check("cmpl_latency", 64'(cyc), 64'((cur_intr ? done_cyc : acc_cyc) + 1));
            if (o_cmpl_v && o_cmpl_r) begin
                check("cmpl_expected", 64'(exp_cmpl_q.size() != 0), 64'd1);
                if (exp_cmpl_q.size() != 0) begin
                    cmpl_exp_t c;
                    c = exp_cmpl_q.pop_front();
                    check("cmpl_aux", 64'(o_cmpl_aux), 64'(c.aux));
                    check("cmpl_err", {63'd0, o_cmpl_err}, {63'd0, c.err});
                    check("cmpl_intr_cnt", 64'(o_intr_cnt), 64'(c.cnt));
                end
            end
        end
        prev_intr_v = o_intr_v;
        prev_cmpl_v = o_cmpl_v;
    end

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int n;
        reset          = 1'b1;
        i_rsp_v        = 1'b0;
        i_rsp_ctxt     = '0;
        i_rsp_nocmpl   = 1'b0;
        i_rsp_sintr_v  = 1'b0;
        i_rsp_sintr_id = '0;
        i_rsp_aux      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: plain completion, no interrupt
        base = n_issue;
        send(9'h00B, 1'b0, 4'd0, 1'b0, 8'h5A, 0);
        wait_drain("t1_drain");
        check("t1_no_intr", 64'(n_issue - base), 64'd0);

        // 2: one interrupt, rc=0
        base = n_issue;
        send(9'h00B, 1'b1, 4'd3, 1'b0, 8'hA5, 0);
        wait_drain("t2_drain");
        check("t2_issues", 64'(n_issue - base), 64'd1);
        check("t2_intr_cnt", 64'(o_intr_cnt), 64'd1);

        // 3: three failing rc then success
        base = n_issue;
        send(mk_ctxt(8'h21, 1'b0), 1'b1, 4'd5, 1'b0, 8'h33, 3);
        wait_drain("t3_drain");
        check("t3_issues", 64'(n_issue - base), 64'((MAX_ATT < 4) ? MAX_ATT : 4));

        // 4: four failing rc
        base = n_issue;
        send(mk_ctxt(8'h47, 1'b0), 1'b1, 4'd9, 1'b0, 8'h44, 4);
        wait_drain("t4_drain");
        check("t4_issues", 64'(n_issue - base), 64'(MAX_ATT));
        check("t4_intr_cnt", 64'(o_intr_cnt), 64'(model_cnt));

        // 5: interrupt with no completion
        base = n_issue;
        send(mk_ctxt(8'h3C, 1'b0), 1'b1, 4'd7, 1'b1, 8'h55, 0);
        wait_drain("t5_drain");
        check("t5_issues", 64'(n_issue - base), 64'd1);

        // 6: bad parity is flagged and sticky; the transaction still completes
        send(mk_ctxt(8'h12, 1'b1), 1'b0, 4'd0, 1'b0, 8'h66, 0);
        wait_drain("t6_drain");
        send(mk_ctxt(8'h13, 1'b0), 1'b0, 4'd0, 1'b0, 8'h67, 0);
        wait_drain("t6b_drain");
        check("t6_perror_sticky", {63'd0, o_perror}, 64'd1);

        // Reset while waiting for the interrupt done
        base = n_issue;
        hold_done = 1'b1;
        send(mk_ctxt(8'h5E, 1'b0), 1'b1, 4'd2, 1'b0, 8'h77, 0);
        n = 0;
        while (n_issue == base && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("rst_wait_reached", 64'(n_issue - base), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_wait");
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_intr_q.delete();
        exp_cmpl_q.delete();
        rc_q.delete();
        model_cnt  = '0;
        model_perr = 1'b0;
        hold_done  = 1'b0;
        send(mk_ctxt(8'h01, 1'b0), 1'b0, 4'd0, 1'b0, 8'h88, 0);
        wait_drain("rst_after_drain");

        // Randomized traffic with random back-pressure
        rand_rdy = 1'b1;
        for (int t = 0; t < 150; t++) begin
            logic [8:0] c;
            c = mk_ctxt(8'($urandom), ($urandom_range(0, 19) == 0));
            send(c, 1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 3) == 0),
                 8'($urandom), int'($urandom_range(0, MAX_ATT)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_drain("rand_drain");
        rand_rdy = 1'b0;

        check("final_intr_q_empty", 64'(exp_intr_q.size()), 64'd0);
        check("final_cmpl_q_empty", 64'(exp_cmpl_q.size()), 64'd0);
        check("final_intr_cnt", 64'(o_intr_cnt), 64'(model_cnt));
        check("final_perror", {63'd0, o_perror}, {63'd0, model_perr});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
